skew_feed_ctrl: RTL and testbench



---
 rtl/skew_feed_ctrl.sv | 135 +++++++++++++
 tb/tb_skew_feed_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/skew_feed_ctrl.sv
// Skewed feeder for a systolic array: lane r delays accepted vectors by r+1 stages.
// Optional stall counter output enabled by defining SKEW_FEED_STALL_CNT_EN.

module skew_lane #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             ld_vld,
  input  logic [WIDTH-1:0] ld_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);
  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else if (clr) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      // bubbles carry zero data so idle lanes present a clean 0 to the array
      vld_pipe[0] <= ld_vld;
      dat_pipe[0] <= ld_vld ? ld_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign out_vld  = vld_pipe[DEPTH-1];
  assign out_data = dat_pipe[DEPTH-1];
endmodule

module skew_feed_ctrl #(
  parameter int ROWS  = 4,
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*WIDTH-1:0] in_data,
  output logic [ROWS*WIDTH-1:0] out_data,
  output logic [ROWS-1:0]       out_valid,
  output logic                  busy,
  output logic                  done
`ifdef SKEW_FEED_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);
  localparam int DW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q, beat_cnt;
  logic [DW-1:0]    drain_cnt;
  logic             accept, start_go, last_beat, drain_end;

  assign in_ready  = (state == FEED);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign start_go  = (state == IDLE) & start & ~flush;
  assign last_beat = accept & ((beat_cnt + LEN_W'(1)) == len_q);
  assign drain_end = (drain_cnt == DW'(ROWS-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len != '0) ? FEED : DONE;
      FEED:    if (last_beat) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else if (flush) begin
      len_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (start_go) len_q <= len;
      if (start_go)    beat_cnt <= '0;
      else if (accept) beat_cnt <= beat_cnt + LEN_W'(1);
      if (state == DRAIN) drain_cnt <= drain_end ? '0 : drain_cnt + DW'(1);
      else                drain_cnt <= '0;
    end
  end

`ifdef SKEW_FEED_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 stall_cnt <= '0;
    else if (flush | start_go) stall_cnt <= '0;
    else if ((state == FEED) && !in_valid && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    skew_lane #(.DEPTH(r+1), .WIDTH(WIDTH)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .clr      (flush),
      .ld_vld   (accept),
      .ld_data  (in_data[r*WIDTH +: WIDTH]),
      .out_vld  (out_valid[r]),
      .out_data (out_data[r*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_skew_feed_ctrl.sv
// Randomized scoreboard bench for skew_feed_ctrl: expected lane outputs and done
// pulses are scheduled from tile plans; a negedge monitor pops and compares.
module tb_skew_feed_ctrl;
  localparam int ROWS  = 4;
  localparam int WIDTH = 8;
  localparam int LEN_W = 8;
  localparam int VW    = ROWS*WIDTH;

  logic clk, reset, start, flush, in_valid, in_ready, busy, done;
  logic [LEN_W-1:0] len;
  logic [VW-1:0]    in_data, out_data;
  logic [ROWS-1:0]  out_valid;
`ifdef SKEW_FEED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  skew_feed_ctrl #(.ROWS(ROWS), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .done(done)
`ifdef SKEW_FEED_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int due; logic [WIDTH-1:0] d;} ent_t;
  ent_t lane_q[ROWS][$];
  int   done_q[$];
  int   n_cmp = 0, n_bad = 0;
  bit   mon_off = 1'b1;
  bit   exp_busy = 1'b0, exp_ready = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drop everything the DUT will not yet have emitted when lanes clear at edge lim
  task automatic purge(input int lim);
    for (int r = 0; r < ROWS; r++)
      while (lane_q[r].size() > 0 && lane_q[r][$].due >= lim) void'(lane_q[r].pop_back());
    done_q.delete();
  endtask

  task automatic clear_all();
    for (int r = 0; r < ROWS; r++) lane_q[r].delete();
    done_q.delete();
  endtask

  always @(negedge clk) begin
    if (!mon_off) begin
      for (int r = 0; r < ROWS; r++) begin
        while (lane_q[r].size() > 0 && lane_q[r][0].due < cyc) begin
          chk("lane_missing_due", cyc, lane_q[r][0].due);
          void'(lane_q[r].pop_front());
        end
        if (out_valid[r]) begin
          if (lane_q[r].size() > 0 && lane_q[r][0].due == cyc) begin
            chk("lane_data", out_data[r*WIDTH +: WIDTH], lane_q[r][0].d);
            void'(lane_q[r].pop_front());
          end else chk("lane_unexpected_valid", out_valid[r], 1'b0);
        end else begin
          chk("lane_bubble_data", out_data[r*WIDTH +: WIDTH], '0);
        end
      end
      while (done_q.size() > 0 && done_q[0] < cyc) begin
        chk("done_missing_due", cyc, done_q[0]);
        void'(done_q.pop_front());
      end
      if (done) begin
        if (done_q.size() > 0 && done_q[0] == cyc) begin
          chk("done_cycle", cyc, done_q[0]);
          void'(done_q.pop_front());
        end else chk("done_unexpected", done, 1'b0);
      end
      chk("busy", busy, exp_busy);
      chk("in_ready", in_ready, exp_ready);
    end
  end

  task automatic chk_stall(input int exp);
`ifdef SKEW_FEED_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, exp);
`else
    if (exp < 0) $display("note: negative stall expectation");
`endif
  endtask

  task automatic idle(input int n);
    start = 1'b0; flush = 1'b0;
    in_valid = 1'($urandom); in_data = VW'($urandom);
    exp_busy = 1'b0; exp_ready = 1'b0;
    repeat (n) tick();
  endtask

  // vmode: 0 all valid, 1 random valid, 2 alternating 1,0,1...
  task automatic run_tile(input int L, input int vmode, input bit dird, input bit hold,
                          input int flush_feed, input int flush_drain, input int rst_beat);
    int beats = 0, stalls = 0, k = 0;
    bit v;
    start = 1'b1; len = LEN_W'(L); flush = 1'b0;
    in_valid = 1'($urandom); in_data = VW'($urandom);
    exp_busy = 1'b0; exp_ready = 1'b0;
    if (L == 0) begin
      done_q.push_back(cyc + 1);
      tick();
      start = hold ? 1'b1 : 1'($urandom); len = LEN_W'($urandom);
      exp_busy = 1'b1; exp_ready = 1'b0;
      tick();
      start = 1'b0; exp_busy = 1'b0;
      chk_stall(0);
      return;
    end
    tick();
    while (beats < L) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 2) ? ((k % 2) == 0) : (($urandom % 4) != 0);
      start = hold ? 1'b1 : 1'($urandom); len = LEN_W'($urandom);
      in_valid = v; in_data = VW'($urandom) | VW'(1);
      exp_busy = 1'b1; exp_ready = 1'b1;
      if (k == rst_beat) begin
        #1 reset = 1'b1;
        #1;
        chk("rst_async_out_valid", out_valid, '0);
        chk("rst_async_out_data", out_data, '0);
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_in_ready", in_ready, 1'b0);
        chk("rst_async_done", done, 1'b0);
        mon_off = 1'b1; clear_all();
        start = 1'b0; exp_busy = 1'b0; exp_ready = 1'b0;
        tick(); tick();
        return;
      end
      if (k == flush_feed) begin
        flush = 1'b1; purge(cyc + 1);
        tick();
        flush = 1'b0; start = 1'b0; exp_busy = 1'b0; exp_ready = 1'b0;
        chk_stall(0);
        return;
      end
      if (v) begin
        if (dird)
          for (int r = 0; r < ROWS; r++) in_data[r*WIDTH +: WIDTH] = WIDTH'(beats*ROWS + r + 1);
        for (int r = 0; r < ROWS; r++)
          lane_q[r].push_back('{due: cyc + 1 + r, d: in_data[r*WIDTH +: WIDTH]});
        beats++;
        if (beats == L) done_q.push_back(cyc + 1 + ROWS);
      end else stalls++;
      k++;
      tick();
    end
    for (int d = 0; d < ROWS; d++) begin
      start = hold ? 1'b1 : 1'($urandom); len = LEN_W'($urandom);
      in_valid = 1'($urandom); in_data = VW'($urandom);
      exp_busy = 1'b1; exp_ready = 1'b0;
      if (d == flush_drain) begin
        flush = 1'b1; purge(cyc + 1);
        tick();
        flush = 1'b0; start = 1'b0; exp_busy = 1'b0;
        chk_stall(0);
        return;
      end
      tick();
    end
    start = hold ? 1'b1 : 1'($urandom); exp_busy = 1'b1; exp_ready = 1'b0;
    tick();
    start = 1'b0; exp_busy = 1'b0;
    chk_stall(stalls);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int L;
    reset = 1'b1; start = 1'b0; flush = 1'b0; len = '0;
    in_valid = 1'b0; in_data = '0;
    #2;
    chk("reset_out_valid", out_valid, '0);
    chk("reset_out_data", out_data, '0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_done", done, 1'b0);
    tick(); tick();
    reset = 1'b0; mon_off = 1'b0;
    idle(2);

    run_tile(3, 0, 1'b1, 1'b0, -1, -1, -1); idle(2);   // three back-to-back beats
    run_tile(2, 2, 1'b0, 1'b0, -1, -1, -1); idle(1);   // 1,0,1 bubble pattern
    run_tile(0, 0, 1'b0, 1'b0, -1, -1, -1); idle(2);   // zero-length tile
    run_tile(3, 0, 1'b0, 1'b0, -1,  0, -1); idle(1);   // flush early in DRAIN
    run_tile(2, 0, 1'b1, 1'b0, -1, -1, -1); idle(1);
    run_tile(1, 0, 1'b0, 1'b1, -1, -1, -1); idle(2);   // start held through tile
    run_tile(5, 0, 1'b0, 1'b0, -1, -1,  2);            // async reset mid-FEED
    reset = 1'b0; mon_off = 1'b0;
    run_tile(2, 1, 1'b0, 1'b0, -1, -1, -1); idle(1);   // start with reset release

    for (int t = 0; t < 30; t++) begin
      L = (($urandom % 8) == 0) ? 0 : (($urandom % 6) == 0) ? 12 : int'($urandom_range(1, 6));
      run_tile(L, int'($urandom_range(0, 2)), 1'($urandom), (($urandom % 4) == 0),
               (($urandom % 6) == 0) ? int'($urandom_range(0, 8)) : -1,
               (($urandom % 6) == 0) ? int'($urandom_range(0, ROWS-1)) : -1, -1);
      idle(int'($urandom_range(0, 2)));
    end

    idle(ROWS + 3);
    for (int r = 0; r < ROWS; r++) chk("lane_queue_empty", lane_q[r].size(), 0);
    chk("done_queue_empty", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
